// File: rtl/mips_decode_queue_if.sv
// Fetch/execute handshake bundle for mips_decode_queue.
// slave = the decode queue, master = the fetch/execute environment.
interface mips_decode_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_dst;
    logic [3:0]  alu__sel;
    logic [3:0]  mem_write_en;
    logic        ctrl_we;
    logic        ctrl_Sys;
    logic        ctrl_RI;
    logic        jmp;
    logic        br;
    logic        memtoreg;
    logic        aluop;
    logic        alusrc2;
    logic        se;
    logic        link;
    logic        lui;
    logic [3:0]  md_op;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs, out_rt, out_dst,
        output alu__sel, mem_write_en, ctrl_we, ctrl_Sys, ctrl_RI,
        output jmp, br, memtoreg, aluop, alusrc2, se, link, lui, md_op
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs, out_rt, out_dst,
        input  alu__sel, mem_write_en, ctrl_we, ctrl_Sys, ctrl_RI,
        input  jmp, br, memtoreg, aluop, alusrc2, se, link, lui, md_op
    );
endinterface

// File: rtl/mips_decode_queue.sv
// Instruction queue with a registered MIPS decode stage at its head.
// Define MIPS_MULDIV_EN to decode the multiply/divide/HI/LO group.
module mips_decode_queue #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   flush,
    mips_decode_queue_if.slave     bus,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;

    typedef struct packed {
        logic [4:0] dst;
        logic [3:0] alu;
        logic [3:0] mwe;
        logic       we;
        logic       sys;
        logic       ri;
        logic       jmp;
        logic       br;
        logic       mtr;
        logic       aluop;
        logic       src2;
        logic       se;
        logic       link;
        logic       lui;
        logic [3:0] md;
    } dec_t;

    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [31:0]   head_inst;
    dec_t          head_dec;
    dec_t          stg;
    logic [31:0]   stg_pc;
    logic [4:0]    stg_rs;
    logic [4:0]    stg_rt;
    logic          stg_valid;
    logic          unused_shamt;

    function automatic dec_t r_alu(input logic [3:0] sel, input logic [4:0] rd,
                                   input logic imm_shift);
        dec_t d;
        d       = '0;
        d.alu   = sel;
        d.aluop = 1'b1;
        d.src2  = imm_shift;
        d.we    = 1'b1;
        d.dst   = rd;
        return d;
    endfunction

    function automatic dec_t decode(input logic [31:0] inst);
        dec_t       d;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        logic [4:0] rd;
        op = inst[31:26];
        fn = inst[5:0];
        rt = inst[20:16];
        rd = inst[15:11];
        d  = '0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h00: d = r_alu(ALU_SLL, rd, 1'b1);
                    6'h02: d = r_alu(ALU_SRL, rd, 1'b1);
                    6'h03: d = r_alu(ALU_SRA, rd, 1'b1);
                    6'h04: d = r_alu(ALU_SLL, rd, 1'b0);
                    6'h06: d = r_alu(ALU_SRL, rd, 1'b0);
                    6'h07: d = r_alu(ALU_SRA, rd, 1'b0);
                    6'h08: d.jmp = 1'b1;
                    6'h09: begin
                        d.jmp  = 1'b1;
                        d.link = 1'b1;
                        d.we   = 1'b1;
                        d.dst  = rd;
                    end
                    6'h0C: d.sys = 1'b1;
`ifdef MIPS_MULDIV_EN
                    6'h18: d.md = 4'd1;
                    6'h19: d.md = 4'd2;
                    6'h1A: d.md = 4'd3;
                    6'h1B: d.md = 4'd4;
                    6'h10: begin
                        d.md  = 4'd5;
                        d.we  = 1'b1;
                        d.dst = rd;
                    end
                    6'h12: begin
                        d.md  = 4'd6;
                        d.we  = 1'b1;
                        d.dst = rd;
                    end
                    6'h11: d.md = 4'd7;
                    6'h13: d.md = 4'd8;
`endif
                    6'h20, 6'h21: d = r_alu(ALU_ADD, rd, 1'b0);
                    6'h22, 6'h23: d = r_alu(ALU_SUB, rd, 1'b0);
                    6'h24: d = r_alu(ALU_AND, rd, 1'b0);
                    6'h25: d = r_alu(ALU_OR,  rd, 1'b0);
                    6'h26: d = r_alu(ALU_XOR, rd, 1'b0);
                    6'h27: d = r_alu(ALU_NOR, rd, 1'b0);
                    6'h2A, 6'h2B: d = r_alu(ALU_SLT, rd, 1'b0);
                    default: d.ri = 1'b1;
                endcase
            end
            6'h01: begin
                case (rt)
                    5'h00, 5'h01: begin
                        d.br  = 1'b1;
                        d.alu = ALU_SUB;
                    end
                    5'h10, 5'h11: begin
                        d.br   = 1'b1;
                        d.alu  = ALU_SUB;
                        d.link = 1'b1;
                        d.we   = 1'b1;
                        d.dst  = 5'd31;
                    end
                    default: d.ri = 1'b1;
                endcase
            end
            6'h02: d.jmp = 1'b1;
            6'h03: begin
                d.jmp  = 1'b1;
                d.link = 1'b1;
                d.we   = 1'b1;
                d.dst  = 5'd31;
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                d.br  = 1'b1;
                d.alu = ALU_SUB;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E: begin
                d.src2 = 1'b1;
                d.we   = 1'b1;
                d.dst  = rt;
                d.se   = (op <= 6'h0B);
                case (op)
                    6'h0A, 6'h0B: d.alu = ALU_SLT;
                    6'h0C:        d.alu = ALU_AND;
                    6'h0D:        d.alu = ALU_OR;
                    6'h0E:        d.alu = ALU_XOR;
                    default:      d.alu = ALU_ADD;
                endcase
            end
            6'h0F: begin
                d.lui  = 1'b1;
                d.src2 = 1'b1;
                d.we   = 1'b1;
                d.dst  = rt;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                d.mtr  = 1'b1;
                d.se   = 1'b1;
                d.src2 = 1'b1;
                d.we   = 1'b1;
                d.dst  = rt;
            end
            6'h28, 6'h29, 6'h2B: begin
                d.se   = 1'b1;
                d.src2 = 1'b1;
                case (op)
                    6'h28:   d.mwe = 4'b0001;
                    6'h29:   d.mwe = 4'b0011;
                    default: d.mwe = 4'b1111;
                endcase
            end
            default: d.ri = 1'b1;
        endcase
        // $0 is never a real write target
        if (d.dst == 5'd0) begin
            d.we = 1'b0;
        end
        return d;
    endfunction

    assign bus.in_ready = (count < CAP);
    assign push = bus.in_valid && bus.in_ready && !flush;
    assign pop  = (count != '0) && (!stg_valid || bus.out_ready) && !flush;

    assign head_inst    = inst_q[rd_ptr];
    assign head_dec     = decode(head_inst);
    assign unused_shamt = ^head_inst[10:6];

    // Queue storage; contents are meaningless outside [rd_ptr, wr_ptr)
    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wr_ptr] <= bus.in_inst;
            pc_q[wr_ptr]   <= bus.in_pc;
        end
    end

    // Pointers and occupancy; flush empties the queue outright
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Output stage: load decoded head, hold under stall, drop when consumed
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            stg_valid <= 1'b0;
            stg       <= '0;
            stg_pc    <= '0;
            stg_rs    <= '0;
            stg_rt    <= '0;
        end else if (flush) begin
            stg_valid <= 1'b0;
        end else if (pop) begin
            stg_valid <= 1'b1;
            stg       <= head_dec;
            stg_pc    <= pc_q[rd_ptr];
            stg_rs    <= head_inst[25:21];
            stg_rt    <= head_inst[20:16];
        end else if (stg_valid && bus.out_ready) begin
            stg_valid <= 1'b0;
        end
    end

    assign bus.out_valid    = stg_valid;
    assign bus.out_pc       = stg_pc;
    assign bus.out_rs       = stg_rs;
    assign bus.out_rt       = stg_rt;
    assign bus.out_dst      = stg.dst;
    assign bus.alu__sel     = stg.alu;
    assign bus.mem_write_en = stg.mwe;
    assign bus.ctrl_we      = stg.we;
    assign bus.ctrl_Sys     = stg.sys;
    assign bus.ctrl_RI      = stg.ri;
    assign bus.jmp          = stg.jmp;
    assign bus.br           = stg.br;
    assign bus.memtoreg     = stg.mtr;
    assign bus.aluop        = stg.aluop;
    assign bus.alusrc2      = stg.src2;
    assign bus.se           = stg.se;
    assign bus.link         = stg.link;
    assign bus.lui          = stg.lui;
    assign bus.md_op        = stg.md;
endmodule

// File: tb/tb_mips_decode_queue.sv
// Testbench for mips_decode_queue: decode table, latency, stall,
// flush and reset sequences checked through an output scoreboard.
module tb_mips_decode_queue;
    localparam int DEPTH = 4;

    localparam logic [3:0] A_ADD = 4'd0;
    localparam logic [3:0] A_SUB = 4'd1;
    localparam logic [3:0] A_AND = 4'd2;
    localparam logic [3:0] A_OR  = 4'd3;
    localparam logic [3:0] A_SLT = 4'd6;
    localparam logic [3:0] A_SLL = 4'd7;

    // flag order: {we,sys,ri,jmp,br,mtr,aluop,src2,se,link,lui}
    localparam logic [10:0] WE   = 11'b100_0000_0000;
    localparam logic [10:0] SYS  = 11'b010_0000_0000;
    localparam logic [10:0] RI   = 11'b001_0000_0000;
    localparam logic [10:0] JMP  = 11'b000_1000_0000;
    localparam logic [10:0] BR   = 11'b000_0100_0000;
    localparam logic [10:0] MTR  = 11'b000_0010_0000;
    localparam logic [10:0] AOP  = 11'b000_0001_0000;
    localparam logic [10:0] SRC2 = 11'b000_0000_1000;
    localparam logic [10:0] SE   = 11'b000_0000_0100;
    localparam logic [10:0] LNK  = 11'b000_0000_0010;
    localparam logic [10:0] LUI  = 11'b000_0000_0001;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [3:0]  alu;
        logic [3:0]  mwe;
        logic [10:0] f;
        logic [3:0]  md;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  count;

    mips_decode_queue_if bus();

    mips_decode_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .flush (flush),
        .bus   (bus),
        .count (count)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    vec_t vq[$];
    bit   mon_en = 1'b0;
    bit   bp_en = 1'b0;
    bit   hold_v = 1'b0;
    exp_t hold_a;
    exp_t act;
    exp_t want;
    exp_t e0;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, req);
        end
    endfunction

    function automatic exp_t mk(logic [31:0] inst, logic [4:0] dst,
                                logic [3:0] alu, logic [3:0] mwe,
                                logic [10:0] f, logic [3:0] md);
        exp_t e;
        e.pc  = '0;
        e.rs  = inst[25:21];
        e.rt  = inst[20:16];
        e.dst = dst;
        e.alu = alu;
        e.mwe = mwe;
        e.f   = f;
        e.md  = md;
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t a;
        a.pc  = bus.out_pc;
        a.rs  = bus.out_rs;
        a.rt  = bus.out_rt;
        a.dst = bus.out_dst;
        a.alu = bus.alu__sel;
        a.mwe = bus.mem_write_en;
        a.f   = {bus.ctrl_we, bus.ctrl_Sys, bus.ctrl_RI, bus.jmp, bus.br,
                 bus.memtoreg, bus.aluop, bus.alusrc2, bus.se, bus.link,
                 bus.lui};
        a.md  = bus.md_op;
        return a;
    endfunction

    task automatic add(logic [31:0] inst, logic [4:0] dst, logic [3:0] alu,
                       logic [3:0] mwe, logic [10:0] f, logic [3:0] md);
        vec_t v;
        v.inst = inst;
        v.e    = mk(inst, dst, alu, mwe, f, md);
        vq.push_back(v);
    endtask

    // Output monitor: scoreboard compare on transfer, stability on stall
    always @(negedge clk) begin
        if (mon_en && rst_b) begin
            act = sample();
            if (hold_v) begin
                total++;
                if (!bus.out_valid || act !== hold_a) begin
                    bad++;
                    $display("FAIL stall_stable: got v=%0b %h want %h",
                             bus.out_valid, act, hold_a);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out: got pc %h want none",
                             bus.out_pc);
                end else begin
                    want = sb.pop_front();
                    if (act !== want) begin
                        bad++;
                        $display("FAIL out_bundle: got %h want %h", act, want);
                    end
                end
            end
            hold_v = bus.out_valid && !bus.out_ready && !flush;
            hold_a = act;
        end else begin
            hold_v = 1'b0;
        end
    end

    // Random consumer backpressure
    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(logic [31:0] inst, logic [31:0] pc, bit track, exp_t e);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got in_ready 0 want 1");
            bus.in_valid = 1'b0;
        end else if (track) begin
            e.pc = pc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            n++;
            tick(1);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d left want 0", sb.size());
            sb.delete();
        end
        chk("empty_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic fill(bit track, logic [31:0] base);
        logic [31:0] inst;
        for (int k = 1; k <= DEPTH + 1; k++) begin
            inst = 32'h2400_0000 | (32'(k) << 16) | 32'(k);
            push(inst, base + 32'(4 * k), track,
                 mk(inst, 5'(k), A_ADD, 4'h0, WE | SRC2 | SE, 4'd0));
        end
    endtask

    initial begin
        e0 = '0;
        add(32'h24020005, 5'd2,  A_ADD, 4'h0, WE | SRC2 | SE, 4'd0);
        add(32'h00221821, 5'd3,  A_ADD, 4'h0, WE | AOP, 4'd0);
        add(32'h00A62022, 5'd4,  A_SUB, 4'h0, WE | AOP, 4'd0);
        add(32'h000838C0, 5'd7,  A_SLL, 4'h0, WE | AOP | SRC2, 4'd0);
        add(32'h0C000010, 5'd31, A_ADD, 4'h0, WE | JMP | LNK, 4'd0);
        add(32'h04310004, 5'd31, A_SUB, 4'h0, WE | BR | LNK, 4'd0);
        add(32'hAC850008, 5'd0,  A_ADD, 4'hF, SRC2 | SE, 4'd0);
        add(32'hFC000000, 5'd0,  A_ADD, 4'h0, RI, 4'd0);
        add(32'h34200001, 5'd0,  A_OR,  4'h0, SRC2, 4'd0);
        add(32'h0000000C, 5'd0,  A_ADD, 4'h0, SYS, 4'd0);
        add(32'h8FA90004, 5'd9,  A_ADD, 4'h0, WE | MTR | SRC2 | SE, 4'd0);
        add(32'h03E00008, 5'd0,  A_ADD, 4'h0, JMP, 4'd0);
        add(32'h3C011234, 5'd1,  A_ADD, 4'h0, WE | LUI | SRC2, 4'd0);
        add(32'h10220003, 5'd0,  A_SUB, 4'h0, BR, 4'd0);
        add(32'hA0A40001, 5'd0,  A_ADD, 4'h1, SRC2 | SE, 4'd0);
        add(32'h00A4302A, 5'd6,  A_SLT, 4'h0, WE | AOP, 4'd0);
        add(32'h3063000F, 5'd3,  A_AND, 4'h0, WE | SRC2, 4'd0);
`ifdef MIPS_MULDIV_EN
        add(32'h00850018, 5'd0,  A_ADD, 4'h0, 11'd0, 4'd1);
        add(32'h00004012, 5'd8,  A_ADD, 4'h0, WE, 4'd6);
`else
        add(32'h00850018, 5'd0,  A_ADD, 4'h0, RI, 4'd0);
        add(32'h00004012, 5'd0,  A_ADD, 4'h0, RI, 4'd0);
`endif

        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        rst_b = 1'b0;
        tick(3);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ctrl_we", 64'(bus.ctrl_we), 64'd0);
        chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
        chk("rst_out_dst", 64'(bus.out_dst), 64'd0);
        rst_b = 1'b1;
        chk("ready_after_rst", 64'(bus.in_ready), 64'd1);
        mon_en = 1'b1;

        // Minimum latency: push at edge N, valid after edge N+1
        bus.out_ready = 1'b1;
        push(vq[0].inst, 32'h0000_0100, 1'b1, vq[0].e);
        chk("lat_edge_n", 64'(bus.out_valid), 64'd0);
        tick(1);
        chk("lat_edge_n1", 64'(bus.out_valid), 64'd1);
        chk("lat_dst", 64'(bus.out_dst), 64'd2);
        drain();

        // Decode table, consumer always ready
        foreach (vq[i]) push(vq[i].inst, 32'h1000 + 32'(4 * i), 1'b1, vq[i].e);
        drain();

        // Decode table again under random backpressure
        bp_en = 1'b1;
        foreach (vq[i]) push(vq[i].inst, 32'h2000 + 32'(4 * i), 1'b1, vq[i].e);
        drain();
        bp_en = 1'b0;
        tick(1);

        // Full stall: DEPTH queued plus one staged, then release in order
        bus.out_ready = 1'b0;
        fill(1'b1, 32'h3000);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        chk("full_count", 64'(count), 64'(DEPTH));
        chk("full_out_pc", 64'(bus.out_pc), 64'h3004);
        tick(3);
        chk("full_count_hold", 64'(count), 64'(DEPTH));
        bus.out_ready = 1'b1;
        drain();

        // Flush with three queued entries and in_valid high
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(vq[k].inst, 32'h4000 + 32'(4 * k), 1'b0, e0);
        chk("pre_flush_count", 64'(count), 64'd3);
        bus.in_valid = 1'b1;
        bus.in_inst  = vq[1].inst;
        bus.in_pc    = 32'h4444;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        tick(4);
        chk("flush_quiet_valid", 64'(bus.out_valid), 64'd0);
        push(vq[2].inst, 32'h4800, 1'b1, vq[2].e);
        drain();

        // Reset while stalled with a full queue
        bus.out_ready = 1'b0;
        fill(1'b0, 32'h5000);
        chk("prerst_in_ready", 64'(bus.in_ready), 64'd0);
        rst_b = 1'b0;
        tick(1);
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrst_ctrl_we", 64'(bus.ctrl_we), 64'd0);
        rst_b = 1'b1;
        bus.out_ready = 1'b1;
        push(vq[4].inst, 32'h5800, 1'b1, vq[4].e);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_decode_queue.md
MIPS_DECODE_QUEUE -- requirements
Module: mips_decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_b  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port flush  input  1  discard all queued and staged instructions.
REQ-005 SHALL have ports in_valid  input  1, in_ready  output  1, in_inst  input  32, in_pc  input  32  fetch-side handshake.
REQ-006 SHALL have ports out_valid  output  1, out_ready  input  1, out_pc  output  32  execute-side handshake.
REQ-007 SHALL have ports out_rs, out_rt, out_dst  output  5 each  source registers and resolved write register.
REQ-008 SHALL have ports alu__sel  output  4 and mem_write_en  output  4, using the codebase ALU_* and byte-mask encodings.
REQ-009 SHALL have 1-bit outputs ctrl_we, ctrl_Sys, ctrl_RI, jmp, br, memtoreg, aluop, alusrc2, se, link, lui.
REQ-010 SHALL have port md_op  output  4  multiply/divide operation, 0 = none.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  current queue occupancy, excluding the output stage.

Function
REQ-012 SHALL push in_inst/in_pc on an edge where in_valid & in_ready & !flush; in_ready = (count < DEPTH), independent of out_ready.
REQ-013 SHALL load the output stage from the queue head on an edge where count > 0 and (!out_valid | out_ready); a decoded bundle is registered, never combinational from in_inst.
REQ-014 SHALL give minimum latency of 2 edges: push at edge N, out_valid high after edge N+1.
REQ-015 SHALL hold every output stable while out_valid & !out_ready.
REQ-016 SHALL clear out_valid after a consumed transfer when the queue is empty.
REQ-017 SHALL keep count unchanged on a simultaneous push and pop; read/write pointers wrap modulo DEPTH.
REQ-018 SHALL, on flush, empty the queue, clear out_valid and ignore in_valid that edge; flush overrides push and pop.
REQ-019 SHALL decode R-type ALU/shift ops as: regdst to rd, aluop=1, shifts by shamt set alusrc2=1; ADDU/SUBU/SLTU share ADD/SUB/SLT.
REQ-020 SHALL decode JR: jmp=1, ctrl_we=0; JALR: jmp=1, link=1, out_dst=rd; SYSCALL: ctrl_Sys=1, ctrl_we=0.
REQ-021 SHALL decode J: jmp=1, ctrl_we=0; JAL: jmp=1, link=1, out_dst=31.
REQ-022 SHALL decode BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ: br=1, ctrl_we=0, alu__sel=SUB; BLTZAL/BGEZAL additionally link=1, ctrl_we=1, out_dst=31.
REQ-023 SHALL decode immediates: ADDI/SLTI se=1; ADDIU/SLTIU se=1; ANDI/ORI/XORI se=0; all alusrc2=1, out_dst=rt.
REQ-024 SHALL decode LUI: lui=1, alusrc2=1, ctrl_we=1, out_dst=rt.
REQ-025 SHALL decode LB/LH/LW/LBU/LHU: memtoreg=1, alu__sel=ADD, se=1, alusrc2=1; SB/SH/SW: ctrl_we=0, mem_write_en 0001/0011/1111.
REQ-026 SHALL decode anything else with ctrl_RI=1, ctrl_we=0, all other controls 0; RI and Sys instructions flow through the queue in order.
REQ-027 SHALL force ctrl_we=0 when out_dst=0.

Reset
REQ-028 SHALL, on clk edge with rst_b=0: pointers and count 0, out_valid 0, all control outputs 0, out_pc/out_rs/out_rt/out_dst 0.
REQ-029 SHALL drive in_ready=1 in the first cycle after reset release; reset overrides flush and any handshake.

Configuration
REQ-030 SHALL, with MIPS_MULDIV_EN defined, decode MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO to md_op 1..8; MFHI/MFLO set ctrl_we=1, out_dst=rd; others ctrl_we=0.
REQ-031 SHALL, without MIPS_MULDIV_EN, tie md_op to 0 and decode those functs with ctrl_RI=1.

Verification
REQ-032 Reset, then push ADDIU $2,$0,5 (0x24020005) with out_ready=1 -> out_valid 2 edges later, out_dst=2, alu__sel=ADD, alusrc2=1, ctrl_we=1.
REQ-033 out_ready=0, push DEPTH+1 instructions -> in_ready low after DEPTH+1 pushes (DEPTH queued, 1 staged), count=DEPTH, outputs stable; release -> program order preserved across pointer wrap.
REQ-034 Queue holding 3 entries, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, flushed inputs never emitted.
REQ-035 Push JAL (0x0C000010), BGEZAL, SW, 0xFC000000 -> link=1/out_dst=31; link=1/br=1/out_dst=31; mem_write_en=1111/ctrl_we=0; ctrl_RI=1.
REQ-036 Push MULT (0x00850018) with and without MIPS_MULDIV_EN -> md_op=1, ctrl_RI=0; md_op=0, ctrl_RI=1.
REQ-037 Assert rst_b=0 mid-stall with full queue -> next edge count=0, out_valid=0, in_ready=1.
